// File: rtl/rv32i_types_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_types_pkg
//
// Shared types and constants for the RV32I front end.
//   word_t           - 32-bit machine word (addresses and instructions)
//   fetch_state_t    - fetch unit state: FETCH_REQ (a read request is
//                      outstanding) or FETCH_HOLD (an instruction is
//                      buffered while decode is stalled)
//   DEFAULT_RESET_PC - first fetch address after reset
//   PC_STEP          - sequential fetch increment (one 32-bit instruction)
//   is_word_aligned  - true when an address has its two low bits clear
// ----------------------------------------------------------------------------
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        FETCH_REQ  = 1'b0,
        FETCH_HOLD = 1'b1
    } fetch_state_t;

    localparam word_t DEFAULT_RESET_PC = 32'h0000_0200;
    localparam word_t PC_STEP          = 32'd4;

    // Only jump/branch targets go through this check; trap vectors and
    // return addresses come from privileged state and are trusted.
    function automatic logic is_word_aligned(input word_t addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_pc_redirect_if.sv
// ----------------------------------------------------------------------------
// fetch_pc_redirect_if
//
// Instruction-memory read channel between the fetch unit and imem.
//   fetch_req  - read request, held high until fetch_ack
//   fetch_addr - read address, stable while fetch_req=1 and fetch_ack=0
//   fetch_ack  - read complete; imem_rdata is valid in the same cycle
//   imem_rdata - returned instruction word
//
// Modports:
//   master - fetch unit side (drives request/address)
//   slave  - memory side (drives ack/data)
// ----------------------------------------------------------------------------
interface fetch_pc_redirect_if;
    import rv32i_types_pkg::*;

    logic  fetch_req;
    word_t fetch_addr;
    logic  fetch_ack;
    word_t imem_rdata;

    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_ack,
        input  imem_rdata
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_pc_redirect.sv
// ----------------------------------------------------------------------------
// fetch_pc_redirect
//
// Program-counter and fetch control for a single-issue RV32I front end.
// Issues one instruction-memory read at a time, hands returned words to
// decode, buffers a word when decode stalls, and steers the PC on taken
// jumps/branches (redirect) and traps/returns (exception).
//
// Parameters:
//   RESET_PC         - first fetch address after reset
//
// Ports:
//   CLK              - clock, all state updates on the rising edge
//   RST              - asynchronous active-high reset
//   redirect_valid   - taken jump/branch from execute
//   redirect_addr    - jump/branch target
//   exception_valid  - trap/return redirect, wins over redirect_valid
//   exception_addr   - trap vector or return PC
//   stall            - decode cannot accept an instruction this cycle
//   imem             - instruction-memory read channel (master side)
//   instr_valid      - instr/instr_pc valid for decode
//   instr            - instruction word to decode
//   instr_pc         - PC of instr
//   misaligned_fault - one-cycle pulse when a redirect target with
//                      addr[1:0] != 0 is rejected
// ----------------------------------------------------------------------------
module fetch_pc_redirect
    import rv32i_types_pkg::*;
#(
    parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       redirect_valid,
    input  word_t                      redirect_addr,
    input  logic                       exception_valid,
    input  word_t                      exception_addr,
    input  logic                       stall,
    fetch_pc_redirect_if.master        imem,
    output logic                       instr_valid,
    output word_t                      instr,
    output word_t                      instr_pc,
    output logic                       misaligned_fault
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    logic         squash_q, squash_d;
    word_t        pending_q, pending_d;
    word_t        buf_instr_q, buf_instr_d;
    word_t        buf_pc_q, buf_pc_d;

    logic         redirect_ok;
    logic         target_valid;
    word_t        target_addr;

    // Target selection. A misaligned jump target is dropped outright so the
    // fetch stream carries on as if no redirect had been requested; the
    // fault pulse lets the pipeline raise the exception. If an exception
    // arrives in the same cycle the redirect is irrelevant, so no fault.
    always_comb begin
        redirect_ok      = redirect_valid && is_word_aligned(redirect_addr);
        target_valid     = exception_valid || redirect_ok;
        target_addr      = exception_valid ? exception_addr : redirect_addr;
        misaligned_fault = !RST && redirect_valid && !exception_valid
                           && !is_word_aligned(redirect_addr);
    end

    // Fetch control. The request address is always pc_q, and pc_q only
    // moves on a cycle where the outstanding read completes (or in HOLD,
    // where nothing is outstanding), which keeps fetch_addr stable for the
    // whole handshake. A redirect that arrives while a read is in flight
    // is parked in pending_q and the in-flight word is squashed when it
    // finally returns.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        squash_d        = squash_q;
        pending_d       = pending_q;
        buf_instr_d     = buf_instr_q;
        buf_pc_d        = buf_pc_q;
        instr_valid     = 1'b0;
        instr           = imem.imem_rdata;
        instr_pc        = pc_q;
        imem.fetch_req  = 1'b0;
        imem.fetch_addr = pc_q;

        case (state_q)
            FETCH_REQ: begin
                imem.fetch_req = 1'b1;
                if (target_valid) begin
                    if (imem.fetch_ack) begin
                        // Read completes in the redirect cycle: drop the
                        // word and start the target fetch right away.
                        pc_d     = target_addr;
                        squash_d = 1'b0;
                    end else begin
                        // Latest redirect wins if one is already parked.
                        pending_d = target_addr;
                        squash_d  = 1'b1;
                    end
                end else if (squash_q) begin
                    if (imem.fetch_ack) begin
                        pc_d     = pending_q;
                        squash_d = 1'b0;
                    end
                end else if (imem.fetch_ack) begin
                    instr_valid = 1'b1;
                    if (stall) begin
                        buf_instr_d = imem.imem_rdata;
                        buf_pc_d    = pc_q;
                        state_d     = FETCH_HOLD;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end

            FETCH_HOLD: begin
                instr    = buf_instr_q;
                instr_pc = buf_pc_q;
                if (target_valid) begin
                    pc_d    = target_addr;
                    state_d = FETCH_REQ;
                end else begin
                    instr_valid = 1'b1;
                    if (!stall) begin
                        pc_d    = buf_pc_q + PC_STEP;
                        state_d = FETCH_REQ;
                    end
                end
            end

            default: begin
                state_d = FETCH_REQ;
            end
        endcase

        // A word that happens to return during reset belongs to a request
        // that reset has abandoned.
        if (RST) begin
            instr_valid = 1'b0;
        end
    end

    // State registers. Reset abandons any outstanding read; the first
    // request afterwards goes to RESET_PC.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= FETCH_REQ;
            pc_q        <= RESET_PC;
            squash_q    <= 1'b0;
            pending_q   <= '0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            squash_q    <= squash_d;
            pending_q   <= pending_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    // Handshake rule: an unacknowledged request keeps its address and stays
    // asserted into the next cycle.
    property p_fetch_addr_stable;
        @(posedge CLK) disable iff (RST)
            (imem.fetch_req && !imem.fetch_ack)
                |=> (imem.fetch_req && $stable(imem.fetch_addr));
    endproperty

    a_fetch_addr_stable: assert property (p_fetch_addr_stable);

endmodule

// File: tb/tb_fetch_pc_redirect.sv
// ----------------------------------------------------------------------------
// tb_fetch_pc_redirect
//
// Directed bench for fetch_pc_redirect. The bench plays instruction memory
// (imem_rdata is a fixed function of fetch_addr, ack is driven per cycle).
// Each vector that should deliver an instruction pushes the expected
// {pc, word} into a queue; a monitor pops and compares whenever decode
// actually takes an instruction (instr_valid=1 and stall=0).
// ----------------------------------------------------------------------------
module tb_fetch_pc_redirect;
    import rv32i_types_pkg::*;

    typedef struct packed {
        word_t pc;
        word_t word;
    } exp_t;

    logic  CLK = 1'b0;
    logic  RST;
    logic  redirect_valid;
    word_t redirect_addr;
    logic  exception_valid;
    word_t exception_addr;
    logic  stall;
    logic  instr_valid;
    word_t instr;
    word_t instr_pc;
    logic  misaligned_fault;

    exp_t  exp_q[$];
    exp_t  mon_e;
    int    checks   = 0;
    int    failures = 0;

    fetch_pc_redirect_if bus ();

    fetch_pc_redirect #(
        .RESET_PC (32'h0000_0200)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .redirect_valid   (redirect_valid),
        .redirect_addr    (redirect_addr),
        .exception_valid  (exception_valid),
        .exception_addr   (exception_addr),
        .stall            (stall),
        .imem             (bus.master),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .misaligned_fault (misaligned_fault)
    );

    always #5 CLK = ~CLK;

    // Memory contents: every word is the bitwise inverse of its address.
    function automatic word_t mem_word(input word_t addr);
        return ~addr;
    endfunction

    assign bus.imem_rdata = mem_word(bus.fetch_addr);

    task automatic check_output(input string name, input word_t actual, input word_t expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, actual, expected);
        end
    endtask

    task automatic expect_fetch(input word_t pc);
        exp_q.push_back('{pc: pc, word: mem_word(pc)});
    endtask

    // Drive one cycle of inputs just after the rising edge, then return at
    // the falling edge so outputs can be sampled.
    task automatic apply_stimulus(input logic ack, input logic stl,
                                  input logic rv = 1'b0, input word_t ra = '0,
                                  input logic ev = 1'b0, input word_t ea = '0);
        @(posedge CLK);
        #1;
        bus.fetch_ack   = ack;
        stall           = stl;
        redirect_valid  = rv;
        redirect_addr   = ra;
        exception_valid = ev;
        exception_addr  = ea;
        @(negedge CLK);
    endtask

    // Scoreboard monitor: compares every instruction decode consumes.
    always @(negedge CLK) begin
        if (RST === 1'b0 && instr_valid === 1'b1 && stall === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_instr at %0t: got pc 0x%08h, expected no delivery", $time, instr_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("sb_instr_pc", instr_pc, mon_e.pc);
                check_output("sb_instr", instr, mon_e.word);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST             = 1'b1;
        bus.fetch_ack   = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_addr   = '0;
        exception_valid = 1'b0;
        exception_addr  = '0;

        // Reset state
        repeat (2) @(negedge CLK);
        check_output("rst_fetch_req", 32'(bus.fetch_req), 32'd1);
        check_output("rst_fetch_addr", bus.fetch_addr, 32'h0000_0200);
        check_output("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_output("rst_fault", 32'(misaligned_fault), 32'd0);
        RST = 1'b0;

        // Sequential fetch, ack every cycle
        expect_fetch(32'h0000_0200);
        apply_stimulus(1'b1, 1'b0);
        check_output("seq0_addr", bus.fetch_addr, 32'h0000_0200);
        check_output("seq0_valid", 32'(instr_valid), 32'd1);
        expect_fetch(32'h0000_0204);
        apply_stimulus(1'b1, 1'b0);
        check_output("seq1_addr", bus.fetch_addr, 32'h0000_0204);
        expect_fetch(32'h0000_0208);
        apply_stimulus(1'b1, 1'b0);
        check_output("seq2_addr", bus.fetch_addr, 32'h0000_0208);

        // Decode stall for three cycles: buffer, hold, release
        expect_fetch(32'h0000_020C);
        apply_stimulus(1'b1, 1'b1);
        check_output("stall_addr", bus.fetch_addr, 32'h0000_020C);
        check_output("stall_valid", 32'(instr_valid), 32'd1);
        apply_stimulus(1'b0, 1'b1);
        check_output("hold_req", 32'(bus.fetch_req), 32'd0);
        check_output("hold_valid", 32'(instr_valid), 32'd1);
        check_output("hold_pc", instr_pc, 32'h0000_020C);
        check_output("hold_instr", instr, 32'hFFFF_FDF3);
        apply_stimulus(1'b0, 1'b1);
        check_output("hold2_req", 32'(bus.fetch_req), 32'd0);
        check_output("hold2_pc", instr_pc, 32'h0000_020C);
        apply_stimulus(1'b0, 1'b0);
        check_output("release_req", 32'(bus.fetch_req), 32'd0);
        check_output("release_valid", 32'(instr_valid), 32'd1);
        expect_fetch(32'h0000_0210);
        apply_stimulus(1'b1, 1'b0);
        check_output("after_hold_addr", bus.fetch_addr, 32'h0000_0210);

        // Redirect while the read is outstanding; ack arrives two cycles later
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0000_1000);
        check_output("redir_addr", bus.fetch_addr, 32'h0000_0214);
        check_output("redir_valid", 32'(instr_valid), 32'd0);
        apply_stimulus(1'b0, 1'b0);
        check_output("redir_wait_addr", bus.fetch_addr, 32'h0000_0214);
        apply_stimulus(1'b1, 1'b0);
        check_output("squash_addr", bus.fetch_addr, 32'h0000_0214);
        check_output("squash_valid", 32'(instr_valid), 32'd0);
        expect_fetch(32'h0000_1000);
        apply_stimulus(1'b1, 1'b0);
        check_output("target_addr", bus.fetch_addr, 32'h0000_1000);

        // Exception and redirect together: exception wins
        apply_stimulus(1'b1, 1'b0, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_0080);
        check_output("exc_cycle_addr", bus.fetch_addr, 32'h0000_1004);
        check_output("exc_cycle_valid", 32'(instr_valid), 32'd0);
        expect_fetch(32'h0000_0080);
        apply_stimulus(1'b1, 1'b0);
        check_output("exc_target_addr", bus.fetch_addr, 32'h0000_0080);

        // Misaligned redirect is rejected, fetch stream carries on
        expect_fetch(32'h0000_0084);
        apply_stimulus(1'b1, 1'b0, 1'b1, 32'h0000_1002);
        check_output("mis_addr", bus.fetch_addr, 32'h0000_0084);
        check_output("mis_fault", 32'(misaligned_fault), 32'd1);
        check_output("mis_valid", 32'(instr_valid), 32'd1);
        expect_fetch(32'h0000_0088);
        apply_stimulus(1'b1, 1'b0);
        check_output("mis_next_addr", bus.fetch_addr, 32'h0000_0088);
        check_output("mis_fault_clear", 32'(misaligned_fault), 32'd0);

        // PC wrap from the top of the address space
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC);
        check_output("wrap_exc_addr", bus.fetch_addr, 32'h0000_008C);
        expect_fetch(32'hFFFF_FFFC);
        apply_stimulus(1'b1, 1'b0);
        check_output("wrap_top_addr", bus.fetch_addr, 32'hFFFF_FFFC);
        expect_fetch(32'h0000_0000);
        apply_stimulus(1'b1, 1'b0);
        check_output("wrap_zero_addr", bus.fetch_addr, 32'h0000_0000);

        // Two redirects while squash pending: the latest one wins
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0000_3000);
        check_output("pend1_addr", bus.fetch_addr, 32'h0000_0004);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0000_4000);
        check_output("pend2_addr", bus.fetch_addr, 32'h0000_0004);
        apply_stimulus(1'b1, 1'b0);
        check_output("pend_squash_valid", 32'(instr_valid), 32'd0);

        // Redirect in HOLD drops the buffered word
        apply_stimulus(1'b1, 1'b1);
        check_output("latest_addr", bus.fetch_addr, 32'h0000_4000);
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0000_5000);
        check_output("hold_redir_req", 32'(bus.fetch_req), 32'd0);
        check_output("hold_redir_valid", 32'(instr_valid), 32'd0);
        expect_fetch(32'h0000_5000);
        apply_stimulus(1'b1, 1'b0);
        check_output("hold_redir_addr", bus.fetch_addr, 32'h0000_5000);

        // Reset in the middle of an outstanding read
        apply_stimulus(1'b0, 1'b0);
        check_output("pre_rst_addr", bus.fetch_addr, 32'h0000_5004);
        @(posedge CLK);
        #1;
        RST           = 1'b1;
        bus.fetch_ack = 1'b1;
        @(negedge CLK);
        check_output("mid_rst_addr", bus.fetch_addr, 32'h0000_0200);
        check_output("mid_rst_valid", 32'(instr_valid), 32'd0);
        @(posedge CLK);
        #1;
        RST           = 1'b0;
        bus.fetch_ack = 1'b0;
        expect_fetch(32'h0000_0200);
        apply_stimulus(1'b1, 1'b0);
        check_output("post_rst_addr", bus.fetch_addr, 32'h0000_0200);
        apply_stimulus(1'b0, 1'b0);

        check_output("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pc_redirect.md
FETCH_PC_REDIRECT -- requirements
Module: fetch_pc_redirect

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0200, the first fetch address after reset.
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port redirect_valid  input  1  taken jump/branch from execute.
REQ-005 SHALL have port redirect_addr  input  32  jump target from the jump-address calculator.
REQ-006 SHALL have port exception_valid  input  1  trap/return redirect, priority over redirect_valid.
REQ-007 SHALL have port exception_addr  input  32  trap vector or return PC.
REQ-008 SHALL have port stall  input  1  decode cannot accept an instruction this cycle.
REQ-009 SHALL have port fetch_req  output  1  instruction-memory read request.
REQ-010 SHALL have port fetch_addr  output  32  instruction-memory read address (word_t).
REQ-011 SHALL have port fetch_ack  input  1  memory read complete; imem_rdata valid this cycle.
REQ-012 SHALL have port imem_rdata  input  32  returned instruction word.
REQ-013 SHALL have port instr_valid  output  1  instr/instr_pc valid for decode.
REQ-014 SHALL have port instr  output  32  instruction to decode.
REQ-015 SHALL have port instr_pc  output  32  PC of instr.
REQ-016 SHALL have port misaligned_fault  output  1  one-cycle pulse: rejected redirect target with addr[1:0]!=0.

Function
REQ-017 SHALL implement states REQ (request outstanding) and HOLD (instruction buffered, decode stalled).
REQ-018 SHALL drive fetch_req=1 and fetch_addr=pc in REQ only; fetch_req=0 in HOLD.
REQ-019 SHALL, in REQ, on fetch_ack with no squash pending and no new redirect: set instr_valid=1 combinationally, instr=imem_rdata, instr_pc=pc.
REQ-020 SHALL, in that case with stall=0, set pc<=pc+4 (modulo 2^32, wraps to 0) and remain in REQ.
REQ-021 SHALL, in that case with stall=1, capture imem_rdata and pc into a buffer and go to HOLD.
REQ-022 SHALL, in HOLD, present instr_valid=1 with buffered instr/instr_pc; on stall=0 set pc<=buffered pc+4 and return to REQ.
REQ-023 SHALL select target = exception_addr when exception_valid, else redirect_addr when redirect_valid; exception wins on simultaneous assertion.
REQ-024 SHALL, on a target in REQ without fetch_ack, latch it as pending and set squash; the next fetch_ack is discarded (instr_valid=0), then pc<=pending target; fetch_req stays high.
REQ-025 SHALL, on a target in REQ with fetch_ack in the same cycle, discard the ack (instr_valid=0) and load pc<=target directly.
REQ-026 SHALL, on a target while squash pending, overwrite the pending target (latest wins).
REQ-027 SHALL, on a target in HOLD, drop the buffer (instr_valid=0 that cycle), load pc<=target, go to REQ.
REQ-028 SHALL reject a redirect_valid target with bits[1:0]!=0: pc and pending state unchanged, misaligned_fault=1 for that cycle; exception targets are never checked.
REQ-029 SHALL hold fetch_addr stable while fetch_req=1 and fetch_ack=0 (handshake rule).

Reset
REQ-030 SHALL, while RST=1, force state=REQ, pc=RESET_PC, squash=0, pending=0, buffer=0, misaligned_fault=0.
REQ-031 SHALL, on RST asserted mid-fetch, abandon the outstanding request; the first post-reset fetch_addr is RESET_PC.

Structure
REQ-032 SHALL place word_t, the fetch state enum, and the RESET_PC default in rv32i_types_pkg.
REQ-033 SHALL need no sub-module; the instruction buffer is a plain register.

Verification
REQ-034 SHALL verify reset then ack every cycle, stall=0 -> fetch_addr 0x200, 0x204, 0x208; instr_valid each ack.
REQ-035 SHALL verify ack with stall=1 for 3 cycles -> HOLD, fetch_req=0, instr/instr_pc held, then fetch_addr=pc+4.
REQ-036 SHALL verify redirect 0x1000 with ack delayed 2 cycles -> that ack dropped, next fetch_addr=0x1000.
REQ-037 SHALL verify exception 0x80 and redirect 0x1000 in the same cycle -> next fetch_addr=0x80.
REQ-038 SHALL verify redirect 0x1002 -> misaligned_fault pulses once; fetch sequence unchanged.
REQ-039 SHALL verify pc=0xFFFF_FFFC accepted -> next fetch_addr=0x0000_0000.
